// File: rtl/fpu_pkg.sv
// Shared single-precision FPU constants and field types used by the
// converter and its sibling FPU blocks.
package fpu_pkg;

  localparam int unsigned F32_BIAS    = 127;
  localparam int unsigned F32_EXP_MAX = 255;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  // Unbiased exponent is 10-bit signed so that exp=0 (-127) and
  // exp=255 (+128) both fit without wrapping.
  typedef logic signed [9:0] f32_exp_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } f32_t;

  // Remove the IEEE-754 bias from a raw 8-bit exponent field.
  function automatic f32_exp_t f32_unbias(input logic [7:0] exp);
    return $signed({2'b00, exp}) - $signed(10'(F32_BIAS));
  endfunction

endpackage

// File: rtl/fpu_unpack.sv
// Combinational split of an IEEE-754 single into sign, unbiased exponent
// and fraction, plus a NaN flag.
module fpu_unpack
  import fpu_pkg::*;
(
  input  logic [31:0] a_i,
  output logic        sign_o,
  output f32_exp_t    exp_o,
  output logic [22:0] frac_o,
  output logic        is_nan_o
);

  f32_t fields;

  // Field extraction; NaN is an all-ones exponent with a nonzero fraction.
  always_comb begin
    fields   = f32_t'(a_i);
    sign_o   = fields.sign;
    exp_o    = f32_unbias(fields.exp);
    frac_o   = fields.frac;
    is_nan_o = (fields.exp == 8'(F32_EXP_MAX)) && (fields.frac != 23'd0);
  end

endmodule

// File: rtl/float_to_int.sv
// Float-to-int32 converter with a strobe/busy handshake on both sides.
// Truncates toward zero; NaN maps to INT32_MIN, out-of-range saturates.
//
//   state         | meaning
//   --------------+-------------------------------------------------------
//   GET_A         | idle, ready for an operand (busy drops on first cycle)
//   UNPACK        | register sign, unbiased exponent and fraction
//   SPECIAL_CASES | NaN / |x|<1 / saturation resolve straight to PUT_Z
//   CONVERT       | single-cycle barrel shift of {1,f} to the magnitude
//   NEGATE        | two's complement when the sign is set
//   PUT_Z         | present result, hold under backpressure
module float_to_int
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        conv_input_STB,
  output logic        conv_BUSY,
  output logic [31:0] output_int,
  output logic        conv_output_STB,
  input  logic        output_module_BUSY
);

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    SPECIAL_CASES,
    CONVERT,
    NEGATE,
    PUT_Z
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic        s_q, s_d;
  f32_exp_t    e_q, e_d;
  logic [22:0] f_q, f_d;
  logic        nan_q, nan_d;
  logic [31:0] z_q, z_d;
  logic        busy_q, busy_d;
  logic        ostb_q, ostb_d;
  logic [31:0] out_q, out_d;

  logic        un_sign;
  f32_exp_t    un_exp;
  logic [22:0] un_frac;
  logic        un_nan;

  fpu_unpack u_unpack (
    .a_i      (a_q),
    .sign_o   (un_sign),
    .exp_o    (un_exp),
    .frac_o   (un_frac),
    .is_nan_o (un_nan)
  );

  logic [31:0] mant_w;
  logic [4:0]  shl_amt;
  logic [4:0]  shr_amt;
  logic [31:0] mag_w;

  // Barrel shifter; only used when 0 <= e <= 30, so both amounts fit 5 bits
  // and the left-shifted magnitude stays below 2^31.
  always_comb begin
    mant_w  = {8'd0, 1'b1, f_q};
    shl_amt = 5'(e_q - 10'sd23);
    shr_amt = 5'(10'sd23 - e_q);
    if (e_q >= 10'sd23) begin
      mag_w = mant_w << shl_amt;
    end else begin
      mag_w = mant_w >> shr_amt;
    end
  end

  // Next-state and datapath updates; every register holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    s_d     = s_q;
    e_d     = e_q;
    f_d     = f_q;
    nan_d   = nan_q;
    z_d     = z_q;
    busy_d  = busy_q;
    ostb_d  = ostb_q;
    out_d   = out_q;

    unique case (state_q)
      GET_A: begin
        busy_d = 1'b0;
        if (conv_input_STB && !busy_q) begin
          a_d     = input_a;
          busy_d  = 1'b1;
          state_d = UNPACK;
        end
      end

      UNPACK: begin
        s_d     = un_sign;
        e_d     = un_exp;
        f_d     = un_frac;
        nan_d   = un_nan;
        state_d = SPECIAL_CASES;
      end

      SPECIAL_CASES: begin
        if (nan_q) begin
          z_d     = INT32_MIN;
          state_d = PUT_Z;
        end else if (e_q < 10'sd0) begin
          z_d     = 32'h0000_0000;
          state_d = PUT_Z;
        end else if (e_q >= 10'sd31) begin
          z_d     = s_q ? INT32_MIN : INT32_MAX;
          state_d = PUT_Z;
        end else begin
          state_d = CONVERT;
        end
      end

      CONVERT: begin
        z_d     = mag_w;
        state_d = NEGATE;
      end

      NEGATE: begin
        if (s_q) begin
          z_d = ~z_q + 32'd1;
        end
        state_d = PUT_Z;
      end

      PUT_Z: begin
        if (ostb_q && !output_module_BUSY) begin
          ostb_d  = 1'b0;
          state_d = GET_A;
        end else begin
          ostb_d = 1'b1;
          out_d  = z_q;
        end
      end

      default: begin
        state_d = GET_A;
      end
    endcase
  end

  // State and datapath registers; reset wins over any FSM action.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= 32'd0;
      s_q     <= 1'b0;
      e_q     <= '0;
      f_q     <= 23'd0;
      nan_q   <= 1'b0;
      z_q     <= 32'd0;
      busy_q  <= 1'b0;
      ostb_q  <= 1'b0;
      out_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      s_q     <= s_d;
      e_q     <= e_d;
      f_q     <= f_d;
      nan_q   <= nan_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      ostb_q  <= ostb_d;
      out_q   <= out_d;
    end
  end

  assign conv_BUSY       = busy_q;
  assign conv_output_STB = ostb_q;
  assign output_int      = out_q;

endmodule

// File: doc/float_to_int.md
FLOAT_TO_INT -- requirements
Module: float_to_int

Interface
REQ-001 The port list SHALL be exactly (clock and reset first):
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, synchronous and active-high.
- input_a  input  32  IEEE-754 single-precision operand, typically the multiplier's output_mult.
- conv_input_STB  input  1  input valid.
- conv_BUSY  output  1  converter cannot accept input.
- output_int  output  32  signed two's-complement result.
- conv_output_STB  output  1  output valid.
- output_module_BUSY  input  1  downstream cannot accept output.

Function
REQ-002 A transaction SHALL occur at any rising edge where conv_input_STB=1 and conv_BUSY=0; input_a SHALL be latched at that edge.
REQ-003 The FSM SHALL have exactly these states: GET_A, UNPACK, SPECIAL_CASES, CONVERT, NEGATE, PUT_Z.
REQ-004 State behaviour SHALL be:
- GET_A: drives conv_BUSY<=0; on a transaction sets conv_BUSY<=1 and goes to UNPACK.
- UNPACK: splits sign s, exponent e=exp-127 (10-bit signed) and fraction f.
- SPECIAL_CASES: goes to PUT_Z on a special result, otherwise to CONVERT.
- CONVERT: goes to NEGATE.
- NEGATE: goes to PUT_Z.
REQ-005 Special results SHALL be, in priority order:
- NaN (exp=255, f!=0) -> 32'h80000000.
- e<0 (zero, denormal, |x|<1) -> 32'h00000000.
- e>=31 with s=0 (includes +inf) -> 32'h7FFFFFFF.
- e>=31 with s=1 (includes -inf and exactly -2^31) -> 32'h80000000.
REQ-006 CONVERT SHALL form the magnitude from M={1,f} (24 bits): M<<(e-23) when e>=23, else M>>(23-e). The result is truncation toward zero, computed in a single barrel-shift cycle.
REQ-007 NEGATE SHALL replace the magnitude with its two's complement when s=1, and leave it unchanged otherwise.
REQ-008 PUT_Z SHALL set conv_output_STB<=1 and output_int<=z. When conv_output_STB=1 and output_module_BUSY=0 at an edge, it SHALL set conv_output_STB<=0 and return to GET_A.
REQ-009 Latency SHALL be counted from acceptance edge T0:
- Normal path: conv_output_STB visible after edge T5.
- Special path: conv_output_STB visible after edge T3.
REQ-010 conv_BUSY SHALL stay 1 from edge T0 through the first GET_A cycle after the handoff, so the earliest next acceptance is 2 edges after the handoff edge.
REQ-011 output_int and conv_output_STB SHALL hold stable while output_module_BUSY=1 (backpressure of unlimited length).
REQ-012 While conv_output_STB=0, output_int SHALL hold its previous valid value.
REQ-013 conv_input_STB asserted while conv_BUSY=1 SHALL be ignored, and input_a changes during that time SHALL have no effect.

Reset
REQ-014 rst SHALL take priority over all FSM actions at the same edge.
REQ-015 Reset SHALL produce state=GET_A, conv_BUSY=0, conv_output_STB=0 and output_int=32'h00000000.
REQ-016 Reset asserted in any state, including PUT_Z under backpressure, SHALL abort the operation with no output produced.

Structure
REQ-017 Package fpu_pkg SHALL hold the shared FPU constants: F32_BIAS=127, F32_EXP_MAX=255, INT32_MAX=32'h7FFFFFFF, INT32_MIN=32'h80000000.
REQ-018 The state typedef SHALL be local to the module.
REQ-019 One sub-module is natural: fpu_unpack, a combinational sign/exponent/fraction split reused by sibling FPU blocks.
REQ-020 The FSM and shifter SHALL stay in float_to_int, with a target of 120-250 lines.

Verification
REQ-021 0x40700000 (3.75) -> output_int 0x00000003, conv_output_STB high after T5.
REQ-022 0xC0200000 (-2.5) -> 0xFFFFFFFE; 0x4B800001 (16777218) -> 0x01000002.
REQ-023 Special inputs, each with STB high after T3:
- 0x4F000000 (2^31) -> 0x7FFFFFFF.
- 0xCF000000 -> 0x80000000.
- 0x7FC00000 (NaN) -> 0x80000000.
- 0xFF800000 (-inf) -> 0x80000000.
REQ-024 0x3F000000 (0.5), 0x00000001 (denormal) and 0x80000000 (-0) -> 0x00000000.
REQ-025 Backpressure and input overlap:
- Stimulus: output_module_BUSY=1 for 10 cycles after STB rises, with a second conv_input_STB held throughout.
- Response: output_int/STB steady; second operand accepted exactly 2 edges after output_module_BUSY falls.
REQ-026 Reset mid-operation:
- Stimulus: rst pulsed in CONVERT.
- Response: STB stays 0, conv_BUSY=0 next cycle, next operand converts correctly.
